ov7670_capture: RTL and testbench

Parametrised camera pixel-capture front end; replaces the fixed 16-bit byte assembler. Samples the OV7670 parallel bus (`din`/`href`/`vsync`) in the `pclk` domain and assembles `BYTES_PER_PIXEL` bytes per pixel, in configurable byte order. Produces a qualified pixel stream with x/y coordinates, frame/line markers, frame-geometry checking and continuous or single-shot capture. Feeds the frame-buffer writer, which sits downstream in the same `pclk` domain.

---
 rtl/ov7670_pkg.sv | 15 +
 rtl/pixel_packer.sv | 59 +++++
 rtl/ov7670_capture.sv | 145 ++++++++++++++
 tb/tb_ov7670_capture.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared FSM state type and default frame geometry for the OV7670 capture block
package ov7670_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        FRAME,
        LINE
    } state_t;

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
    localparam int DEF_BPP    = 2;

endpackage

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - assembles BYTES_PER_PIXEL camera bytes into one pixel word with optional byte swap
module pixel_packer #(
    parameter int DIN_W           = 8,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int BYTE_SWAP       = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DIN_W-1:0]                   din,
    input  logic                               en,
    output logic [DIN_W*BYTES_PER_PIXEL-1:0]   dout,
    output logic                               dout_valid,
    output logic                               done,
    output logic                               partial
);

    localparam int OUT_W = DIN_W * BYTES_PER_PIXEL;

    logic [OUT_W-1:0] sr;
    logic [OUT_W-1:0] full;
    logic [OUT_W-1:0] ordered;
    logic [1:0]       cnt;

    assign done    = en && (cnt == 2'(BYTES_PER_PIXEL - 1));
    assign partial = (cnt != 2'd0);

    // Stale high bytes of sr fall off the top as new bytes shift in.
    always_comb begin
        full    = (sr << DIN_W) | OUT_W'(din);
        ordered = full;
        if (BYTE_SWAP != 0) begin
            for (int i = 0; i < BYTES_PER_PIXEL; i++) begin
                ordered[i*DIN_W +: DIN_W] = full[(BYTES_PER_PIXEL-1-i)*DIN_W +: DIN_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= '0;
            cnt        <= 2'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (!en) begin
                cnt <= 2'd0;
            end else if (done) begin
                dout       <= ordered;
                dout_valid <= 1'b1;
                cnt        <= 2'd0;
            end else begin
                sr  <= full;
                cnt <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 capture front end: input registers, frame FSM, coordinates and geometry checks
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int DIN_W           = 8,
    parameter int BYTES_PER_PIXEL = DEF_BPP,
    parameter int BYTE_SWAP       = 0,
    parameter int X_W             = 10,
    parameter int Y_W             = 9,
    parameter int EXP_WIDTH       = DEF_WIDTH,
    parameter int EXP_HEIGHT      = DEF_HEIGHT
) (
    input  logic                               pclk,
    input  logic                               reset_n,
    input  logic [DIN_W-1:0]                   din,
    input  logic                               vsync,
    input  logic                               href,
    input  logic                               capture_en,
    input  logic                               single_shot,
    output logic [DIN_W*BYTES_PER_PIXEL-1:0]   dout,
    output logic                               dout_valid,
    output logic [X_W-1:0]                     pix_x,
    output logic [Y_W-1:0]                     pix_y,
    output logic                               sof,
    output logic                               eol,
    output logic                               eof,
    output logic                               busy,
    output logic                               frame_err,
    output logic [15:0]                        frame_count
);

    logic [DIN_W-1:0] din_q;
    logic             href_q, vsync_q, vsync_prev;
    state_t           state;
    logic [X_W-1:0]   x_cnt;
    logic [Y_W-1:0]   y_cnt, y_after;
    logic             first_pix, shot_done;
    logic             capturing, pack_en, pix_done, partial;
    logic             line_end, frame_end, abort, err_any;

    assign capturing = (state == FRAME) || (state == LINE);
    assign pack_en   = capturing && href_q;

    pixel_packer #(
        .DIN_W          (DIN_W),
        .BYTES_PER_PIXEL(BYTES_PER_PIXEL),
        .BYTE_SWAP      (BYTE_SWAP)
    ) u_packer (
        .clk       (pclk),
        .rst_n     (reset_n),
        .din       (din_q),
        .en        (pack_en),
        .dout      (dout),
        .dout_valid(dout_valid),
        .done      (pix_done),
        .partial   (partial)
    );

    // A vsync rise while href is still high aborts the line; a pixel completing in that cycle still counts.
    always_comb begin
        line_end  = (state == LINE) && !href_q;
        frame_end = capturing && vsync_q;
        abort     = (state == LINE) && href_q && vsync_q;
        y_after   = y_cnt;
        if (line_end && !(&y_cnt)) y_after = y_cnt + 1'b1;
        err_any = 1'b0;
        if (line_end && (partial || (x_cnt != X_W'(EXP_WIDTH)) || (&y_cnt))) err_any = 1'b1;
        if (pix_done && (&x_cnt)) err_any = 1'b1;
        if (frame_end && (abort || (y_after != Y_W'(EXP_HEIGHT)))) err_any = 1'b1;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            din_q       <= '0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            vsync_prev  <= 1'b0;
            state       <= IDLE;
            x_cnt       <= '0;
            y_cnt       <= '0;
            first_pix   <= 1'b0;
            shot_done   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            din_q      <= din;
            href_q     <= href;
            vsync_q    <= vsync;
            vsync_prev <= vsync_q;
            sof        <= 1'b0;
            eol        <= 1'b0;
            eof        <= 1'b0;
            if (!capture_en) shot_done <= 1'b0;
            if (pix_done) begin
                pix_x     <= x_cnt;
                pix_y     <= y_cnt;
                sof       <= first_pix;
                first_pix <= 1'b0;
                if (!(&x_cnt)) x_cnt <= x_cnt + 1'b1;
            end
            if (err_any) frame_err <= 1'b1;
            case (state)
                IDLE:  if (capture_en && !shot_done) state <= SYNC;
                SYNC: begin
                    if (!capture_en) begin
                        state <= IDLE;
                    end else if (vsync_prev && !vsync_q) begin
                        state     <= FRAME;
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
                        first_pix <= 1'b1;
                        x_cnt     <= '0;
                        y_cnt     <= '0;
                    end
                end
                FRAME: if (href_q) state <= LINE;
                LINE: begin
                    if (line_end) begin
                        eol   <= 1'b1;
                        x_cnt <= '0;
                        y_cnt <= y_after;
                        state <= FRAME;
                    end
                end
                default: state <= IDLE;
            endcase
            if (frame_end) begin
                eof         <= 1'b1;
                busy        <= 1'b0;
                frame_count <= frame_count + 16'd1;
                x_cnt       <= '0;
                y_cnt       <= '0;
                if (single_shot) shot_done <= 1'b1;
                state <= (capture_en && !single_shot) ? SYNC : IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - scoreboard bench for ov7670_capture with straight and byte-swapped instances
module tb_ov7670_capture;

    typedef struct {
        logic [15:0] data;
        int          x;
        int          y;
        logic        first;
        int          cyc;
    } pix_t;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        vsync, href, capture_en, single_shot;

    logic [15:0] dout, s_dout;
    logic        dv, s_dv;
    logic [9:0]  pix_x, s_pix_x;
    logic [8:0]  pix_y, s_pix_y;
    logic        sof, eol, eof, busy, ferr;
    logic        s_sof, s_eol, s_eof, s_busy, s_ferr;
    logic [15:0] fcnt, s_fcnt;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    logic [7:0] bval;
    pix_t pix_q[$];
    int   eol_q[$];
    int   eof_q[$];
    pix_t mon_e;
    int   mon_c;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    ov7670_capture #(.BYTES_PER_PIXEL(2), .BYTE_SWAP(0), .EXP_WIDTH(4), .EXP_HEIGHT(2)) u_dut (
        .pclk(pclk), .reset_n(rst_n), .din(din), .vsync(vsync), .href(href),
        .capture_en(capture_en), .single_shot(single_shot), .dout(dout), .dout_valid(dv),
        .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol), .eof(eof), .busy(busy),
        .frame_err(ferr), .frame_count(fcnt)
    );

    ov7670_capture #(.BYTES_PER_PIXEL(2), .BYTE_SWAP(1), .EXP_WIDTH(4), .EXP_HEIGHT(2)) u_swap (
        .pclk(pclk), .reset_n(rst_n), .din(din), .vsync(vsync), .href(href),
        .capture_en(capture_en), .single_shot(single_shot), .dout(s_dout), .dout_valid(s_dv),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .sof(s_sof), .eol(s_eol), .eof(s_eof), .busy(s_busy),
        .frame_err(s_ferr), .frame_count(s_fcnt)
    );

    always @(negedge pclk) begin
        if (mon_en) begin
            if (dv) begin
                tests++;
                if (pix_q.size() == 0) begin
                    fails++;
                    $display("FAIL pixel_unexpected: got dout=%h at cyc %0d, none expected", dout, cyc);
                end else begin
                    mon_e = pix_q.pop_front();
                    if ({dout, pix_x, pix_y, sof} !== {mon_e.data, 10'(mon_e.x), 9'(mon_e.y), mon_e.first}
                        || cyc != mon_e.cyc) begin
                        fails++;
                        $display("FAIL pixel: got %h (%0d,%0d) sof=%b cyc=%0d, want %h (%0d,%0d) sof=%b cyc=%0d",
                                 dout, pix_x, pix_y, sof, cyc, mon_e.data, mon_e.x, mon_e.y, mon_e.first, mon_e.cyc);
                    end
                    tests++;
                    if ({s_dv, s_dout, s_pix_x, s_pix_y, s_sof} !==
                        {1'b1, mon_e.data[7:0], mon_e.data[15:8], 10'(mon_e.x), 9'(mon_e.y), mon_e.first}) begin
                        fails++;
                        $display("FAIL swap_pixel: got valid=%b %h, want valid=1 %h",
                                 s_dv, s_dout, {mon_e.data[7:0], mon_e.data[15:8]});
                    end
                end
            end else if (sof || s_dv) begin
                tests++;
                fails++;
                $display("FAIL stray_strobe: sof=%b swap_valid=%b without pixel, want 0", sof, s_dv);
            end
            if (eol) begin
                tests++;
                mon_c = (eol_q.size() == 0) ? -1 : eol_q.pop_front();
                if (mon_c != cyc || s_eol !== 1'b1) begin
                    fails++;
                    $display("FAIL eol: got cyc %0d swap_eol=%b, want cyc %0d swap_eol=1", cyc, s_eol, mon_c);
                end
            end
            if (eof) begin
                tests++;
                mon_c = (eof_q.size() == 0) ? -1 : eof_q.pop_front();
                if (mon_c != cyc || s_eof !== 1'b1) begin
                    fails++;
                    $display("FAIL eof: got cyc %0d swap_eof=%b, want cyc %0d swap_eof=1", cyc, s_eof, mon_c);
                end
            end
        end
    end

    task automatic drive(input logic [7:0] d, input logic h, input logic v);
        @(posedge pclk);
        #1;
        din   = d;
        href  = h;
        vsync = v;
    endtask

    // Two lines; line 0 has first_len bytes, line 1 has len bytes. abort raises vsync on the last byte of line 1.
    task automatic send_frame(input int first_len, input int len, input bit cap, input bit abort);
        logic [7:0] prev = 8'h00;
        bit         first = 1'b1;
        pix_t       p;
        repeat (3) drive(8'h00, 1'b0, 1'b1);
        repeat (2) drive(8'h00, 1'b0, 1'b0);
        for (int l = 0; l < 2; l++) begin
            int n = (l == 0) ? first_len : len;
            for (int j = 0; j < n; j++) begin
                bit ab = abort && (l == 1) && (j == n - 1);
                drive(bval, 1'b1, ab);
                if (cap && (j % 2 == 1)) begin
                    p.data  = {prev, bval};
                    p.x     = j / 2;
                    p.y     = l;
                    p.first = first;
                    p.cyc   = cyc + 2;
                    pix_q.push_back(p);
                    first = 1'b0;
                end
                if (cap && ab) eof_q.push_back(cyc + 2);
                prev = bval;
                bval = bval + 8'h11;
            end
            if (abort && l == 1) begin
                repeat (3) drive(8'h00, 1'b0, 1'b1);
                return;
            end
            drive(8'h00, 1'b0, 1'b0);
            if (cap) eol_q.push_back(cyc + 2);
            repeat (2) drive(8'h00, 1'b0, 1'b0);
        end
        drive(8'h00, 1'b0, 1'b1);
        if (cap) eof_q.push_back(cyc + 2);
        repeat (3) drive(8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge pclk);
        #1;
        tests++;
        if ({dout, dv, pix_x, pix_y, sof, eol, eof, busy, ferr, fcnt} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got dout=%h busy=%b fcnt=%0d, want all 0", dout, busy, fcnt);
        end
        tests++;
        if ({s_dout, s_dv, s_busy, s_ferr, s_fcnt} !== '0) begin
            fails++;
            $display("FAIL reset_swap_outputs: got dout=%h fcnt=%0d, want all 0", s_dout, s_fcnt);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        bval = 8'h11;
        capture_en = 1'b1;
        send_frame(8, 8, 1'b1, 1'b0);
        repeat (2) drive(8'h00, 1'b0, 1'b1);
        tests++;
        if ({fcnt, s_fcnt, ferr, busy} !== {16'd1, 16'd1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL basic_status: got fcnt=%0d err=%b busy=%b, want 1 0 0", fcnt, ferr, busy);
        end
        tests++;
        if (pix_q.size() + eol_q.size() + eof_q.size() != 0) begin
            fails++;
            $display("FAIL basic_drain: got %0d outstanding events, want 0", pix_q.size() + eol_q.size() + eof_q.size());
        end
    endtask

    task automatic test_short_line();
        send_frame(7, 8, 1'b1, 1'b0);
        repeat (2) drive(8'h00, 1'b0, 1'b1);
        tests++;
        if ({fcnt, ferr, s_ferr} !== {16'd2, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL short_line: got fcnt=%0d err=%b, want 2 1", fcnt, ferr);
        end
        tests++;
        if (pix_q.size() + eol_q.size() + eof_q.size() != 0) begin
            fails++;
            $display("FAIL short_drain: got %0d outstanding events, want 0", pix_q.size() + eol_q.size() + eof_q.size());
        end
    endtask

    task automatic test_vsync_abort();
        send_frame(8, 4, 1'b1, 1'b1);
        repeat (2) drive(8'h00, 1'b0, 1'b1);
        tests++;
        if ({fcnt, ferr, busy} !== {16'd3, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL vsync_abort: got fcnt=%0d err=%b busy=%b, want 3 1 0", fcnt, ferr, busy);
        end
        tests++;
        if (pix_q.size() + eol_q.size() + eof_q.size() != 0) begin
            fails++;
            $display("FAIL abort_drain: got %0d outstanding events, want 0", pix_q.size() + eol_q.size() + eof_q.size());
        end
    endtask

    task automatic test_single_shot();
        single_shot = 1'b1;
        send_frame(8, 8, 1'b1, 1'b0);
        send_frame(8, 8, 1'b0, 1'b0);
        repeat (2) drive(8'h00, 1'b0, 1'b1);
        tests++;
        if ({fcnt, ferr, busy, s_busy} !== {16'd4, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL single_shot_status: got fcnt=%0d err=%b busy=%b, want 4 0 0", fcnt, ferr, busy);
        end
        tests++;
        if (u_dut.state !== ov7670_pkg::IDLE) begin
            fails++;
            $display("FAIL single_shot_state: got %0d, want IDLE", u_dut.state);
        end
        tests++;
        if (pix_q.size() + eol_q.size() + eof_q.size() != 0) begin
            fails++;
            $display("FAIL single_drain: got %0d outstanding events, want 0", pix_q.size() + eol_q.size() + eof_q.size());
        end
        single_shot = 1'b0;
        capture_en  = 1'b0;
        repeat (2) drive(8'h00, 1'b0, 1'b1);
        capture_en  = 1'b1;
    endtask

    task automatic test_reset_midline();
        mon_en = 1'b0;
        repeat (3) drive(8'h00, 1'b0, 1'b1);
        repeat (2) drive(8'h00, 1'b0, 1'b0);
        repeat (3) drive(8'h5A, 1'b1, 1'b0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_midframe: got %b, want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({dout, dv, pix_x, pix_y, sof, eol, eof, busy, ferr, fcnt, s_fcnt, s_busy} !== '0) begin
            fails++;
            $display("FAIL async_reset: got dout=%h busy=%b fcnt=%0d, want all 0", dout, busy, fcnt);
        end
        pix_q.delete();
        eol_q.delete();
        eof_q.delete();
        mon_en = 1'b1;
        repeat (2) drive(8'hA5, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (3) drive(8'hA5, 1'b1, 1'b0);
        repeat (3) drive(8'h00, 1'b0, 1'b0);
        repeat (8) drive(8'h3C, 1'b1, 1'b0);
        repeat (3) drive(8'h00, 1'b0, 1'b0);
        bval = 8'h11;
        send_frame(8, 8, 1'b1, 1'b0);
        repeat (2) drive(8'h00, 1'b0, 1'b1);
        tests++;
        if ({fcnt, s_fcnt, ferr, busy} !== {16'd1, 16'd1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_recovery: got fcnt=%0d err=%b busy=%b, want 1 0 0", fcnt, ferr, busy);
        end
        tests++;
        if (pix_q.size() + eol_q.size() + eof_q.size() != 0) begin
            fails++;
            $display("FAIL reset_drain: got %0d outstanding events, want 0", pix_q.size() + eol_q.size() + eof_q.size());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        din         = 8'h00;
        href        = 1'b0;
        vsync       = 1'b0;
        capture_en  = 1'b0;
        single_shot = 1'b0;
        bval        = 8'h11;
        test_reset();
        test_basic();
        test_short_line();
        test_vsync_abort();
        test_single_shot();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
